// File: rtl/disp_pkg.sv
// Shared display-pipeline types and constants: 12-bit {r,g,b} colour,
// default palette colours and the blink phase encoding.
package disp_pkg;

    localparam int COLOR_W = 12;
    localparam int POS_W   = 11;

    typedef logic [COLOR_W-1:0] rgb12;

    localparam rgb12 C_PURPLE = 12'h213;
    localparam rgb12 C_ORANGE = 12'hf73;
    localparam rgb12 C_SKY    = 12'h7cc;

    typedef enum logic {
        PH_VISIBLE = 1'b0,
        PH_HIDDEN  = 1'b1
    } blink_phase_t;

    // Power-on palette: entry 0 purple, entry 1 orange, the rest black.
    function automatic rgb12 default_color(input int idx);
        case (idx)
            0:       return C_PURPLE;
            1:       return C_ORANGE;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/banner_palette.sv
// Indexed-colour palette: 2^BPP x 12-bit register file with one synchronous
// write port and one combinational read port.
module banner_palette
    import disp_pkg::*;
#(
    parameter int BPP = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [BPP-1:0] widx,
    input  rgb12           wdata,
    input  logic [BPP-1:0] ridx,
    output rgb12           rdata
);

    localparam int N_ENTRIES = 1 << BPP;

    rgb12 mem [N_ENTRIES];

    // A same-cycle read of the index being written sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                mem[i] <= default_color(i);
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/banner_renderer.sv
// Renders an indexed-colour image region from an external ROM with
// horizontal scroll and blink; outputs are aligned to the ROM latency.
//
// Blink phase FSM:
//   state      | meaning
//   PH_VISIBLE | region pixels take their palette colour
//   PH_HIDDEN  | region pixels forced to BG_COLOR (in_region unaffected)
module banner_renderer
    import disp_pkg::*;
#(
    parameter int   X0           = 0,
    parameter int   Y0           = 0,
    parameter int   IMG_W        = 1440,
    parameter int   IMG_H        = 100,
    parameter int   BPP          = 1,
    parameter int   ADDR_W       = 18,
    parameter int   ROM_LAT      = 1,
    parameter rgb12 BG_COLOR     = 12'h7cc,
    parameter int   SCROLL_STEP  = 2,
    parameter int   BLINK_FRAMES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [POS_W-1:0]  pos_x,
    input  logic [POS_W-1:0]  pos_y,
    input  logic              pos_valid,
    input  logic              frame_tick,
    input  logic              scroll_en,
    input  logic              blink_en,
    input  logic              pal_we,
    input  logic [BPP-1:0]    pal_idx,
    input  rgb12              pal_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [BPP-1:0]    rom_data,
    output logic [3:0]        pix_r,
    output logic [3:0]        pix_g,
    output logic [3:0]        pix_b,
    output logic              in_region,
    output logic              pix_valid
);

    localparam logic [11:0]       X_LO    = 12'(X0);
    localparam logic [11:0]       Y_LO    = 12'(Y0);
    localparam logic [11:0]       W_12    = 12'(IMG_W);
    localparam logic [11:0]       H_12    = 12'(IMG_H);
    localparam logic [11:0]       STEP_12 = 12'(SCROLL_STEP);
    localparam logic [ADDR_W-1:0] W_A     = ADDR_W'(IMG_W);
    localparam int                BC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BC_W-1:0]   BC_LAST = BC_W'(BLINK_FRAMES - 1);

    logic [11:0]       scroll_off;
    logic [11:0]       scroll_sum;
    logic [11:0]       scroll_next;
    logic [11:0]       dx;
    logic [11:0]       dy;
    logic [11:0]       col_raw;
    logic [11:0]       col;
    logic              hit;
    logic [ADDR_W-1:0] addr_d;

    logic [ROM_LAT-1:0] hit_dl;
    logic [ROM_LAT-1:0] val_dl;

    blink_phase_t     phase;
    blink_phase_t     phase_next;
    logic [BC_W-1:0]  bcnt;
    logic [BC_W-1:0]  bcnt_next;
    logic             blanked;

    rgb12 pal_rd;
    rgb12 pix_q;

    // Left/above the region the subtraction wraps past 2047, so a single
    // unsigned "< size" test covers both edges without overflowing.
    always_comb begin
        dx      = {1'b0, pos_x} - X_LO;
        dy      = {1'b0, pos_y} - Y_LO;
        hit     = pos_valid && (dx < W_12) && (dy < H_12);
        col_raw = dx + scroll_off;
        col     = (col_raw >= W_12) ? (col_raw - W_12) : col_raw;
        addr_d  = hit ? (ADDR_W'(dy) * W_A + ADDR_W'(col)) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= '0;
            hit_dl   <= '0;
            val_dl   <= '0;
        end else begin
            rom_addr <= addr_d;
            hit_dl   <= ROM_LAT'({hit_dl, hit});
            val_dl   <= ROM_LAT'({val_dl, pos_valid});
        end
    end

    always_comb begin
        scroll_sum  = scroll_off + STEP_12;
        scroll_next = (scroll_sum >= W_12) ? (scroll_sum - W_12) : scroll_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scroll_off <= '0;
        end else if (frame_tick && scroll_en) begin
            scroll_off <= scroll_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= PH_VISIBLE;
            bcnt  <= '0;
        end else begin
            phase <= phase_next;
            bcnt  <= bcnt_next;
        end
    end

    always_comb begin
        phase_next = phase;
        bcnt_next  = bcnt;
        if (!blink_en) begin
            phase_next = PH_VISIBLE;
            bcnt_next  = '0;
        end else if (frame_tick) begin
            if (bcnt == BC_LAST) begin
                bcnt_next  = '0;
                phase_next = (phase == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
            end else begin
                bcnt_next = bcnt + 1'b1;
            end
        end
    end

    assign blanked = blink_en && (phase == PH_HIDDEN);

    banner_palette #(
        .BPP (BPP)
    ) u_palette (
        .clk   (clk),
        .rst   (rst),
        .we    (pal_we),
        .widx  (pal_idx),
        .wdata (pal_data),
        .ridx  (rom_data),
        .rdata (pal_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q     <= BG_COLOR;
            in_region <= 1'b0;
            pix_valid <= 1'b0;
        end else begin
            pix_q     <= (hit_dl[ROM_LAT-1] && !blanked) ? pal_rd : BG_COLOR;
            in_region <= hit_dl[ROM_LAT-1];
            pix_valid <= val_dl[ROM_LAT-1];
        end
    end

    assign {pix_r, pix_g, pix_b} = pix_q;

endmodule

// File: tb/tb_banner_renderer.sv
// Bench for banner_renderer: a default instance and an offset 2-bpp,
// 3-cycle-ROM instance, checked against a frame-level model every cycle.
module tb_banner_renderer;
    import disp_pkg::*;

    localparam int IMG_W = 1440;
    localparam int IMG_H = 100;
    localparam int X0S[2]   = '{0, 100};
    localparam int Y0S[2]   = '{0, 50};
    localparam int LATS[2]  = '{1, 3};
    localparam int BFS[2]   = '{32, 4};
    localparam int MASKS[2] = '{1, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] pos_x = '0;
    logic [10:0] pos_y = '0;
    logic        pos_valid = 1'b0;
    logic        frame_tick = 1'b0;
    logic        scroll_en = 1'b0;
    logic        blink_en = 1'b0;
    logic        pal_we = 1'b0;
    logic [1:0]  pal_idx = '0;
    logic [11:0] pal_data = '0;

    logic [17:0] rom_addr_a, rom_addr_b;
    logic        rom_data_a;
    logic [1:0]  rom_data_b;
    logic [3:0]  ra, ga, ba, rb, gb, bb;
    logic        inr_a, inr_b, pv_a, pv_b;
    logic [11:0] pix_a, pix_b;
    logic [17:0] ah1 = '0;
    logic [17:0] ah2 = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic img_a(input logic [17:0] a);
        return a[0] ^ a[3];
    endfunction

    function automatic logic [1:0] img_b(input logic [17:0] a);
        return a[1:0] ^ a[5:4];
    endfunction

    // External ROMs: A answers combinationally (1-cycle latency at the output
    // register), B holds the address two more cycles (3-cycle latency).
    assign rom_data_a = img_a(rom_addr_a);
    always @(posedge clk) begin
        ah1 <= rom_addr_b;
        ah2 <= ah1;
    end
    assign rom_data_b = img_b(ah2);

    assign pix_a = {ra, ga, ba};
    assign pix_b = {rb, gb, bb};

    banner_renderer u_a (
        .clk        (clk),
        .rst        (rst),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .pos_valid  (pos_valid),
        .frame_tick (frame_tick),
        .scroll_en  (scroll_en),
        .blink_en   (blink_en),
        .pal_we     (pal_we),
        .pal_idx    (pal_idx[0]),
        .pal_data   (pal_data),
        .rom_addr   (rom_addr_a),
        .rom_data   (rom_data_a),
        .pix_r      (ra),
        .pix_g      (ga),
        .pix_b      (ba),
        .in_region  (inr_a),
        .pix_valid  (pv_a)
    );

    banner_renderer #(
        .X0           (100),
        .Y0           (50),
        .BPP          (2),
        .ROM_LAT      (3),
        .BLINK_FRAMES (4)
    ) u_b (
        .clk        (clk),
        .rst        (rst),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .pos_valid  (pos_valid),
        .frame_tick (frame_tick),
        .scroll_en  (scroll_en),
        .blink_en   (blink_en),
        .pal_we     (pal_we),
        .pal_idx    (pal_idx),
        .pal_data   (pal_data),
        .rom_addr   (rom_addr_b),
        .rom_data   (rom_data_b),
        .pix_r      (rb),
        .pix_g      (gb),
        .pix_b      (bb),
        .in_region  (inr_b),
        .pix_valid  (pv_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model state
    int          m_scroll [2];
    int          m_bcnt   [2];
    bit          m_hidden [2];
    logic [11:0] m_pal    [2][4];
    bit          q_hit    [2][4];
    bit          q_val    [2][4];
    int          q_addr   [2][4];
    logic [17:0] e_addr   [2];
    logic [11:0] e_pix    [2];
    logic        e_inr    [2];
    logic        e_pv     [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_scroll[k] = 0;
            m_bcnt[k]   = 0;
            m_hidden[k] = 0;
            m_pal[k][0] = 12'h213;
            m_pal[k][1] = 12'hf73;
            m_pal[k][2] = 12'h000;
            m_pal[k][3] = 12'h000;
            for (int i = 0; i < 4; i++) begin
                q_hit[k][i]  = 0;
                q_val[k][i]  = 0;
                q_addr[k][i] = 0;
            end
            e_addr[k] = '0;
            e_pix[k]  = 12'h7cc;
            e_inr[k]  = 1'b0;
            e_pv[k]   = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int dx, dy, a, lat, ix;
            bit hit, blank;
            lat   = LATS[k];
            dx    = int'(pos_x) - X0S[k];
            dy    = int'(pos_y) - Y0S[k];
            hit   = pos_valid && dx >= 0 && dx < IMG_W && dy >= 0 && dy < IMG_H;
            a     = hit ? dy * IMG_W + (dx + m_scroll[k]) % IMG_W : 0;
            blank = blink_en && m_hidden[k];
            if (q_hit[k][lat-1] && !blank) begin
                ix = (k == 0) ? int'(img_a(18'(q_addr[k][lat-1])))
                              : int'(img_b(18'(q_addr[k][lat-1])));
                e_pix[k] = m_pal[k][ix];
            end else begin
                e_pix[k] = 12'h7cc;
            end
            e_inr[k] = q_hit[k][lat-1];
            e_pv[k]  = q_val[k][lat-1];
            for (int i = 3; i > 0; i--) begin
                q_hit[k][i]  = q_hit[k][i-1];
                q_val[k][i]  = q_val[k][i-1];
                q_addr[k][i] = q_addr[k][i-1];
            end
            q_hit[k][0]  = hit;
            q_val[k][0]  = pos_valid;
            q_addr[k][0] = a;
            e_addr[k]    = 18'(a);
            if (pal_we) m_pal[k][int'(pal_idx) & MASKS[k]] = pal_data;
            if (!blink_en) begin
                m_bcnt[k]   = 0;
                m_hidden[k] = 0;
            end else if (frame_tick) begin
                m_bcnt[k]++;
                if (m_bcnt[k] == BFS[k]) begin
                    m_bcnt[k]   = 0;
                    m_hidden[k] = !m_hidden[k];
                end
            end
            if (frame_tick && scroll_en) m_scroll[k] = (m_scroll[k] + 2) % IMG_W;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("a_addr_model", 32'(rom_addr_a), 32'(e_addr[0]));
            chk("a_pix_model",  32'(pix_a),      32'(e_pix[0]));
            chk("a_inr_model",  32'(inr_a),      32'(e_inr[0]));
            chk("a_pv_model",   32'(pv_a),       32'(e_pv[0]));
            chk("b_addr_model", 32'(rom_addr_b), 32'(e_addr[1]));
            chk("b_pix_model",  32'(pix_b),      32'(e_pix[1]));
            chk("b_inr_model",  32'(inr_b),      32'(e_inr[1]));
            chk("b_pv_model",   32'(pv_b),       32'(e_pv[1]));
        end
    end

    task automatic apply(input int x, input int y, input bit v);
        pos_x     = 11'(x);
        pos_y     = 11'(y);
        pos_valid = v;
        @(negedge clk);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        apply(0, 0, 0);
        frame_tick = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_addr_a", 32'(rom_addr_a), 32'd0);
        chk("rst_pix_a",  32'(pix_a),      32'h7cc);
        chk("rst_pv_b",   32'(pv_b),       32'd0);
        chk("rst_inr_b",  32'(inr_b),      32'd0);
        rst = 1'b0;

        // Default instance: first pixels and right-edge miss
        apply(0, 0, 1);
        chk("a_addr_0_0", 32'(rom_addr_a), 32'd0);
        apply(1, 0, 1);
        chk("a_addr_1_0", 32'(rom_addr_a), 32'd1);
        chk("a_pix_0_0",  32'(pix_a),      32'h213);
        chk("a_inr_0_0",  32'(inr_a),      32'd1);
        apply(2, 0, 1);
        chk("a_pix_1_0",  32'(pix_a),      32'hf73);
        chk("a_inr_1_0",  32'(inr_a),      32'd1);
        apply(1440, 5, 1);
        chk("a_addr_1440_5", 32'(rom_addr_a), 32'd0);
        apply(0, 0, 0);
        chk("a_pix_1440_5", 32'(pix_a), 32'h7cc);
        chk("a_inr_1440_5", 32'(inr_a), 32'd0);
        chk("a_pv_1440_5",  32'(pv_a),  32'd1);

        // Offset instance address math and edges
        apply(100, 50, 1);
        chk("b_addr_100_50", 32'(rom_addr_b), 32'd0);
        apply(101, 51, 1);
        chk("b_addr_101_51", 32'(rom_addr_b), 32'd1441);
        apply(99, 50, 1);
        chk("b_addr_99_50", 32'(rom_addr_b), 32'd0);
        apply(100, 150, 1);
        apply(0, 0, 0);
        apply(0, 0, 0);
        chk("b_inr_99_50", 32'(inr_b), 32'd0);
        chk("b_pv_99_50",  32'(pv_b),  32'd1);
        apply(0, 0, 0);
        chk("b_inr_100_150", 32'(inr_b), 32'd0);
        chk("b_pv_100_150",  32'(pv_b),  32'd1);

        // Scroll wrap
        scroll_en = 1'b1;
        repeat (719) tick();
        apply(1, 0, 1);
        chk("a_addr_719", 32'(rom_addr_a), 32'd1439);
        apply(101, 50, 1);
        chk("b_addr_719", 32'(rom_addr_b), 32'd1439);
        frame_tick = 1'b1;
        apply(1, 0, 1);
        frame_tick = 1'b0;
        chk("a_addr_tick_old", 32'(rom_addr_a), 32'd1439);
        apply(1, 0, 1);
        chk("a_addr_720", 32'(rom_addr_a), 32'd1);
        apply(101, 50, 1);
        chk("b_addr_720", 32'(rom_addr_b), 32'd1);
        scroll_en = 1'b0;
        tick();
        apply(1, 0, 1);
        chk("a_addr_hold", 32'(rom_addr_a), 32'd1);

        // Short raster across edges with scroll_off = 2
        scroll_en = 1'b1;
        tick();
        scroll_en = 1'b0;
        foreach (Y0S[r]) begin
            for (int x = 1430; x < 1446; x++) apply(x, Y0S[r] + 1, 1);
            for (int x = 1534; x < 1546; x++) apply(x, Y0S[r] + IMG_H - 1, 1);
            for (int x = 94; x < 106; x++)  apply(x, Y0S[r] + IMG_H, 1);
        end
        repeat (4) apply(0, 0, 0);

        // Blink on the offset instance: (104,55) -> addr 7206 -> index 0
        blink_en = 1'b1;
        for (int f = 0; f < 8; f++) begin
            apply(104, 55, 1);
            repeat (3) apply(0, 0, 0);
            chk("b_blink_pix", 32'(pix_b), (f < 4) ? 32'h213 : 32'h7cc);
            chk("b_blink_inr", 32'(inr_b), 32'd1);
            if (f < 7) tick();
        end
        blink_en = 1'b0;
        apply(104, 55, 1);
        repeat (3) apply(0, 0, 0);
        chk("b_unblank", 32'(pix_b), 32'h213);

        // Palette writes: (103,55) -> index 3, (105,55) -> index 1
        pal_we = 1'b1; pal_idx = 2'd3; pal_data = 12'h0f0;
        apply(0, 0, 0);
        pal_we = 1'b0;
        apply(103, 55, 1);
        repeat (3) apply(0, 0, 0);
        chk("b_pal3", 32'(pix_b), 32'h0f0);
        apply(105, 55, 1);
        apply(0, 0, 0);
        apply(0, 0, 0);
        pal_we = 1'b1; pal_idx = 2'd1; pal_data = 12'habc;
        apply(0, 0, 0);
        pal_we = 1'b0;
        chk("b_pal_same_cycle", 32'(pix_b), 32'hf73);
        apply(105, 55, 1);
        repeat (3) apply(0, 0, 0);
        chk("b_pal_new", 32'(pix_b), 32'habc);

        // Asynchronous reset in the middle of a busy line
        scroll_en = 1'b1;
        tick();
        scroll_en = 1'b0;
        for (int x = 100; x < 108; x++) apply(x, 60, 1);
        pos_x = 11'd110; pos_y = 11'd60; pos_valid = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_pv_b",   32'(pv_b),       32'd0);
        chk("rst_async_pix_b",  32'(pix_b),      32'h7cc);
        chk("rst_async_inr_b",  32'(inr_b),      32'd0);
        chk("rst_async_addr_b", 32'(rom_addr_b), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        apply(0, 0, 0);
        chk("post_rst_idle0", 32'(pv_b), 32'd0);
        apply(0, 0, 0);
        chk("post_rst_idle1", 32'(pv_b), 32'd0);
        apply(101, 50, 1);
        chk("post_rst_scroll", 32'(rom_addr_b), 32'd1);
        chk("post_rst_pv1",    32'(pv_b),       32'd0);
        apply(0, 0, 0);
        chk("post_rst_pv2", 32'(pv_b), 32'd0);
        apply(0, 0, 0);
        chk("post_rst_pv3", 32'(pv_b), 32'd0);
        apply(0, 0, 0);
        chk("post_rst_pv4", 32'(pv_b), 32'd1);
        repeat (2) apply(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/banner_renderer.md
Name: banner_renderer

Overview:
- Parametrised successor to the fixed top-banner painter in the VGA game pipeline.
- Renders a rectangular image region anywhere on screen from an external indexed-colour ROM:
  - 1, 2 or 4 bits per pixel, looked up in a runtime-writable 12-bit palette.
  - Per-frame horizontal scroll with wrap-around.
  - Optional blink.
- Output is pipeline-aligned to the ROM read latency, so `in_region` and colour arrive together at the display mux.

Parameters:
- X0, 0, region left edge (pixels)
- Y0, 0, region top edge (lines)
- IMG_W, 1440, region/image width
- IMG_H, 100, region/image height
- BPP, 1, bits per pixel; legal values are 1, 2 and 4
- ADDR_W, 18, ROM address width; IMG_W*IMG_H must be ≤ 2^ADDR_W
- ROM_LAT, 1, ROM read latency in cycles (≥1)
- BG_COLOR, 12'h7cc, colour driven outside the region or when blanked
- SCROLL_STEP, 2, pixels added to scroll offset per enabled frame
- BLINK_FRAMES, 32, frames per blink half-period

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- pos_x  in  11  current pixel x
- pos_y  in  11  current pixel y
- pos_valid  in  1  pos_x/pos_y valid this cycle
- frame_tick  in  1  one-cycle pulse at start of each frame
- scroll_en  in  1  enable scroll advance on frame_tick
- blink_en  in  1  enable blinking
- pal_we  in  1  palette write strobe
- pal_idx  in  BPP  palette write index
- pal_data  in  12  palette write colour {r,g,b}
- rom_addr  out  ADDR_W  ROM read address (registered)
- rom_data  in  BPP  ROM pixel index, valid ROM_LAT cycles after rom_addr
- pix_r  out  4  red
- pix_g  out  4  green
- pix_b  out  4  blue
- in_region  out  1  pixel lies inside the region
- pix_valid  out  1  aligned copy of pos_valid

Behaviour:
- Reset values:
  - rom_addr=0, in_region=0, pix_valid=0, pix_* = BG_COLOR.
  - scroll_off=0, blink counter=0, blink phase=visible.
  - Palette: entry 0=12'h213, entry 1=12'hf73, all others 12'h000.
  - Reset may assert mid-line. All pipeline valid bits clear immediately, and no stale pixel is emitted after release.
- Stage 0 (cycle 1):
  - hit = pos_valid & X0≤pos_x<X0+IMG_W & Y0≤pos_y<Y0+IMG_H.
  - If hit: rom_addr <= (pos_y−Y0)*IMG_W + ((pos_x−X0+scroll_off) mod IMG_W). The modulo is a single conditional subtract, since scroll_off<IMG_W.
  - If not hit: rom_addr <= 0.
  - hit and pos_valid enter a delay line ROM_LAT deep.
- Output stage (cycle ROM_LAT+1):
  - If delayed hit & !blanked: pix_* <= palette[rom_data].
  - Otherwise: pix_* <= BG_COLOR.
  - in_region <= delayed hit; pix_valid <= delayed pos_valid.
  - Total latency from pos_* to outputs is ROM_LAT+1 cycles, fully pipelined with one pixel per cycle.
- Scroll:
  - On frame_tick & scroll_en: scroll_off <= (scroll_off+SCROLL_STEP) mod IMG_W. The wrap is exact, e.g. 1439+2 → 1.
  - On frame_tick & !scroll_en: scroll_off holds.
  - A pixel sampled in the same cycle as frame_tick uses the old offset.
- Blink:
  - While blink_en=0: counter=0, phase=visible.
  - While blink_en=1: each frame_tick increments the counter. At BLINK_FRAMES−1 the counter wraps to 0 and the phase toggles.
  - blanked = blink_en & phase==hidden.
  - in_region still reports geometry while blanked.
- Palette:
  - Written synchronously on pal_we.
  - A write and a read of the same index in the same cycle returns the old value; the new value is visible the following cycle.
- Arithmetic:
  - Address product computed at ADDR_W bits; no truncation for legal parameters.
  - Edge comparisons use 12-bit unsigned, so X0+IMG_W=2047 must not overflow.

Decomposition:
- Shared package `disp_pkg`:
  - COLOR_W=12, POS_W=11.
  - Default palette constants: C_PURPLE=12'h213, C_ORANGE=12'hf73, C_SKY=12'h7cc.
  - rgb12 typedef.
- One sub-module, `banner_palette`:
  - Register-file palette of 2^BPP × 12 bits.
  - Synchronous write port, combinational read port.
  - Resets to the defaults above.

Test Plan:
- Reset then raster, all defaults, rom_data driven from a model of a 1-bit image: at pos (0,0), rom_addr=0 after 1 cycle. rom_data=1 gives pix=f73 and in_region=1 two cycles after pos. At pos (1440,5), pix=7cc and in_region=0.
- Address math, X0=100, Y0=50: at pos (100,50) rom_addr=0. At (101,51) rom_addr=1441. At (99,50) and (100,150), in_region=0.
- Scroll wrap, IMG_W=1440, SCROLL_STEP=2: 720 frame_ticks with scroll_en=1 bring scroll_off to 0. After 719 ticks, pos (X0+1,Y0) gives rom_addr=1439; after 720 ticks it gives rom_addr=1.
- Blink, BLINK_FRAMES=4, blink_en=1: frames 0–3 show palette colour, frames 4–7 show 7cc with in_region still 1. Dropping blink_en restores visibility on the next pixel.
- Palette, BPP=2: write idx 3=12'h0f0, then rom_data=3 gives pix=0f0. Same-cycle write and read of idx 1 yields the old f73.
- Async reset mid-line with ROM_LAT=3: assert rst between clock edges. pix_valid=0 and pix=7cc immediately, scroll_off=0. After release, the first valid output appears exactly 4 cycles after the first pos_valid.
